frame_grabber: RTL and testbench

// - Parametrised single-frame grabber on the VGA pixel stream (same clock as VGA controller).
// - Arms on iStart, skips SKIP_FRAMES frames, then writes one frame window into on-chip RAM.
// - Window origin/size, channel/luma select and power-of-two subsampling are configurable.
// - Signals completion and freezes the camera so the grabbed frame stays on screen.

---
 rtl/capture_pkg.sv | 31 +++
 rtl/frame_grabber_if.sv | 12 +
 rtl/frame_window_addr.sv | 39 +++
 rtl/frame_grabber.sv | 143 ++++++++++++++
 tb/tb_frame_grabber.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/capture_pkg.sv
// Shared encodings and the luma helper for the frame grabber.
package capture_pkg;

    localparam int PIX_W   = 10;
    localparam int COORD_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_RED,
        MODE_GREEN,
        MODE_BLUE,
        MODE_LUMA
    } mode_e;

    // (R + 2G + B) / 4 in a 12-bit sum, so full-scale inputs cannot overflow.
    function automatic logic [PIX_W-1:0] luma(input logic [PIX_W-1:0] r,
                                              input logic [PIX_W-1:0] g,
                                              input logic [PIX_W-1:0] b);
        logic [PIX_W+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[PIX_W+1:2];
    endfunction

endpackage

// File: rtl/frame_grabber_if.sv
// RAM write port driven by the grabber (master) and consumed by the frame store (slave).
interface frame_grabber_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 10
);
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemData;
    logic              oMemWE;

    modport master (output oMemAddr, output oMemData, output oMemWE);
    modport slave  (input  oMemAddr, input  oMemData, input  oMemWE);
endinterface

// File: rtl/frame_window_addr.sv
// Combinational window hit test (half-open bounds, subsample alignment) and raster address.
module frame_window_addr
    import capture_pkg::*;
#(
    parameter int H_START  = 144,
    parameter int V_START  = 35,
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int SUB_LOG2 = 0,
    parameter int ADDR_W   = 15
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               hit_o,
    output logic [ADDR_W-1:0]  addr_o
);
    localparam logic [COORD_W:0] X_LO     = (COORD_W+1)'(H_START);
    localparam logic [COORD_W:0] X_HI     = (COORD_W+1)'(H_START + H_RES);
    localparam logic [COORD_W:0] Y_LO     = (COORD_W+1)'(V_START);
    localparam logic [COORD_W:0] Y_HI     = (COORD_W+1)'(V_START + V_RES);
    localparam logic [COORD_W:0] SUB_MASK = (COORD_W+1)'((1 << SUB_LOG2) - 1);
    localparam int               ROW_W    = H_RES >> SUB_LOG2;

    logic [COORD_W:0] x_ext, y_ext, dx, dy;
    logic             in_x, in_y, aligned;

    assign x_ext = {1'b0, x_i};
    assign y_ext = {1'b0, y_i};
    assign dx    = x_ext - X_LO;
    assign dy    = y_ext - Y_LO;

    assign in_x    = (x_ext >= X_LO) && (x_ext < X_HI);
    assign in_y    = (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign aligned = ((dx & SUB_MASK) == '0) && ((dy & SUB_MASK) == '0);
    assign hit_o   = in_x && in_y && aligned;

    // Row stride is the subsampled window width, so the frame packs densely from 0.
    assign addr_o = ADDR_W'(32'(dy >> SUB_LOG2) * 32'(ROW_W) + 32'(dx >> SUB_LOG2));
endmodule

// File: rtl/frame_grabber.sv
// Single-frame grabber: arms on iStart, skips settling frames, stores one windowed
// frame to RAM with one cycle of latency, then holds oStopCapture until iStart drops.
module frame_grabber
    import capture_pkg::*;
#(
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_RES       = 160,
    parameter int V_RES       = 120,
    parameter int SUB_LOG2    = 0,
    parameter int DATA_W      = 10,
    parameter int ADDR_W      = 15,
    parameter int SKIP_FRAMES = 300,
    parameter int SOF_X       = 0,
    parameter int SOF_Y       = 0
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [PIX_W-1:0]   iRed,
    input  logic [PIX_W-1:0]   iGreen,
    input  logic [PIX_W-1:0]   iBlue,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic               iStart,
    input  logic [1:0]         iMode,
    frame_grabber_if.master    mem,
    output logic               oBusy,
    output logic               oReady,
    output logic               oStopCapture,
    output logic               oLed
);
    localparam int CNT_W = $clog2(SKIP_FRAMES + 2);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mode_e              mode_q, mode_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               we_q, we_d;

    logic               sof, hit;
    logic [ADDR_W-1:0]  win_addr;
    logic [PIX_W-1:0]   pix;

    assign sof = (iX == COORD_W'(SOF_X)) && (iY == COORD_W'(SOF_Y));

    frame_window_addr #(
        .H_START (H_START),
        .V_START (V_START),
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .SUB_LOG2(SUB_LOG2),
        .ADDR_W  (ADDR_W)
    ) u_win (
        .x_i   (iX),
        .y_i   (iY),
        .hit_o (hit),
        .addr_o(win_addr)
    );

    always_comb begin
        unique case (mode_q)
            MODE_RED:   pix = iRed;
            MODE_GREEN: pix = iGreen;
            MODE_BLUE:  pix = iBlue;
            MODE_LUMA:  pix = luma(iRed, iGreen, iBlue);
        endcase
    end

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (iStart) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!iStart)                            state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(SKIP_FRAMES))  state_d = ST_WAIT_SOF;
                else if (sof && cnt_q != '1)            cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_SOF: begin
                if (!iStart) begin
                    state_d = ST_IDLE;
                end else if (sof) begin
                    state_d = ST_CAPTURE;
                    mode_d  = mode_e'(iMode);
                end
            end
            ST_CAPTURE: begin
                // Abort outranks both the closing sof and any pending pixel write.
                if (!iStart) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sof) state_d = ST_DONE;
                    if (hit) begin
                        we_d   = 1'b1;
                        addr_d = win_addr;
                        data_d = pix[PIX_W-1 -: DATA_W];
                    end
                end
            end
            ST_DONE: begin
                if (!iStart) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_RED;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    assign mem.oMemAddr = addr_q;
    assign mem.oMemData = data_q;
    assign mem.oMemWE   = we_q;

    assign oBusy        = (state_q == ST_ARM) || (state_q == ST_WAIT_SOF) || (state_q == ST_CAPTURE);
    assign oReady       = (state_q == ST_DONE);
    assign oStopCapture = (state_q == ST_DONE);
    assign oLed         = (state_q == ST_CAPTURE) || (state_q == ST_DONE);
endmodule

// File: tb/tb_frame_grabber.sv
// Scoreboard bench: two grabbers (full-rate and 2x subsampled) watch one 40x20 test raster.
module tb_frame_grabber;
    typedef struct {
        logic [5:0] addr;
        logic [9:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  r, g, b;
    logic [12:0] x, y;
    logic        start;
    logic [1:0]  mode;
    logic        busy0, ready0, stop0, led0;
    logic        busy1, ready1, stop1, led1;

    int  n_cmp = 0;
    int  n_err = 0;
    int  pat   = 0;
    bit  sb_on = 1'b1;
    int  wr_cnt0 = 0, wr_cnt1 = 0;
    int  sof_cnt = 0, first_sof = -1, ready_cnt = 0;
    wr_t q0[$], q1[$];
    logic [9:0] ram0 [64];
    logic [9:0] ram1 [64];

    frame_grabber_if #(.ADDR_W(6), .DATA_W(10)) m0 ();
    frame_grabber_if #(.ADDR_W(6), .DATA_W(10)) m1 ();

    frame_grabber #(
        .H_START(10), .V_START(5), .H_RES(8), .V_RES(4), .SUB_LOG2(0),
        .DATA_W(10), .ADDR_W(6), .SKIP_FRAMES(2), .SOF_X(0), .SOF_Y(0)
    ) dut0 (
        .iCLK(clk), .iRST_N(rst_n), .iRed(r), .iGreen(g), .iBlue(b),
        .iX(x), .iY(y), .iStart(start), .iMode(mode), .mem(m0),
        .oBusy(busy0), .oReady(ready0), .oStopCapture(stop0), .oLed(led0)
    );

    frame_grabber #(
        .H_START(10), .V_START(5), .H_RES(8), .V_RES(4), .SUB_LOG2(1),
        .DATA_W(10), .ADDR_W(6), .SKIP_FRAMES(2), .SOF_X(0), .SOF_Y(0)
    ) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .iRed(r), .iGreen(g), .iBlue(b),
        .iX(x), .iY(y), .iStart(start), .iMode(mode), .mem(m1),
        .oBusy(busy1), .oReady(ready1), .oStopCapture(stop1), .oLed(led1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // 40x20 raster, one pixel per clock, driven just after each rising edge.
    initial begin
        int vx = 0;
        int vy = 0;
        x = '0; y = '0; r = '0; g = '0; b = '0;
        forever begin
            @(posedge clk);
            #1;
            x = 13'(vx);
            y = 13'(vy);
            if (pat == 0) begin
                r = 10'(vx + 16 * vy);
                g = 10'd0;
                b = 10'd0;
            end else begin
                r = 10'd100;
                g = 10'd200;
                b = 10'd40;
            end
            vx++;
            if (vx == 40) begin
                vx = 0;
                vy = (vy == 19) ? 0 : vy + 1;
            end
        end
    end

    // Monitor: pops the expected write whenever a grabber strobes oMemWE.
    always @(negedge clk) begin
        wr_t e;
        if (start && busy0 && x == 13'd0 && y == 13'd0) sof_cnt++;
        if (ready0 || ready1) ready_cnt++;
        if (m0.oMemWE) begin
            if (wr_cnt0 == 0) first_sof = sof_cnt;
            wr_cnt0++;
            if (sb_on) begin
                if (q0.size() == 0) begin
                    check("dut0_unexpected_write", 32'(m0.oMemAddr), 32'hFFFF);
                end else begin
                    e = q0.pop_front();
                    check("dut0_addr", 32'(m0.oMemAddr), 32'(e.addr));
                    check("dut0_data", 32'(m0.oMemData), 32'(e.data));
                    ram0[m0.oMemAddr] = m0.oMemData;
                end
            end
        end
        if (m1.oMemWE) begin
            wr_cnt1++;
            if (sb_on) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_write", 32'(m1.oMemAddr), 32'hFFFF);
                end else begin
                    e = q1.pop_front();
                    check("dut1_addr", 32'(m1.oMemAddr), 32'(e.addr));
                    check("dut1_data", 32'(m1.oMemData), 32'(e.data));
                    ram1[m1.oMemAddr] = m1.oMemData;
                end
            end
        end
    end

    // Expected frame in raster order: lum=1 means constant 135, else R = x + 16*y.
    task automatic push_frame(input bit lum);
        for (int a = 0; a < 32; a++) begin
            int px = 10 + a % 8;
            int py = 5 + a / 8;
            q0.push_back('{addr: 6'(a), data: lum ? 10'd135 : 10'(px + 16 * py)});
        end
        for (int a = 0; a < 8; a++) begin
            int px = 10 + 2 * (a % 4);
            int py = 5 + 2 * (a / 4);
            q1.push_back('{addr: 6'(a), data: lum ? 10'd135 : 10'(px + 16 * py)});
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (!(ready0 && ready1) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(ready0 && ready1), 32'd1);
    endtask

    task automatic wait_writes(input string name, input int cnt, input int budget);
        int n = 0;
        while (wr_cnt0 < cnt && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(wr_cnt0 >= cnt), 32'd1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_we"},    32'({m0.oMemWE, m1.oMemWE}), 32'd0);
        check({name, "_busy"},  32'({busy0, busy1}), 32'd0);
        check({name, "_ready"}, 32'({ready0, ready1, stop0, stop1}), 32'd0);
        check({name, "_led"},   32'({led0, led1}), 32'd0);
    endtask

    initial begin
        int snap0, snap1;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Full capture, red channel, both subsample settings.
        pat = 0; mode = 2'd0; wr_cnt0 = 0; wr_cnt1 = 0; sof_cnt = 0; first_sof = -1;
        push_frame(1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("arm_busy", 32'({busy0, busy1}), 32'd3);
        wait_ready("cap1_done", 4000);
        check("cap1_stop", 32'({stop0, stop1, led0, led1, busy0, busy1}), 32'b111100);
        check("cap1_wr0", 32'(wr_cnt0), 32'd32);
        check("cap1_wr1", 32'(wr_cnt1), 32'd8);
        check("cap1_q_empty", 32'(q0.size() + q1.size()), 32'd0);
        check("cap1_first_sof", 32'(first_sof), 32'd3);
        check("cap1_ram0_9", 32'(ram0[9]), 32'd107);
        check("cap1_ram0_31", 32'(ram0[31]), 32'd145);
        check("cap1_ram1_5", 32'(ram1[5]), 32'd124);
        repeat (900) @(posedge clk);
        #1;
        check("done_hold", 32'({ready0, ready1, stop0, stop1}), 32'hF);
        check("done_no_wr", 32'(wr_cnt0 + wr_cnt1), 32'd40);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("done_release");

        // Re-arm in luma mode; a mid-frame mode change must not matter.
        pat = 1; mode = 2'd3; wr_cnt0 = 0; wr_cnt1 = 0;
        push_frame(1'b1);
        start = 1'b1;
        wait_writes("luma_started", 5, 4000);
        mode = 2'd0;
        wait_ready("luma_done", 4000);
        check("luma_q_empty", 32'(q0.size() + q1.size()), 32'd0);
        check("luma_ram0_9", 32'(ram0[9]), 32'd135);
        check("luma_ram1_7", 32'(ram1[7]), 32'd135);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("luma_release");

        // Abort while arming.
        sb_on = 1'b0; pat = 0; mode = 2'd0; wr_cnt0 = 0; wr_cnt1 = 0;
        start = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("arm_abort_pre", 32'({busy0, busy1}), 32'd3);
        start = 1'b0;
        ready_cnt = 0;
        @(posedge clk);
        #1;
        check_idle("arm_abort");
        repeat (3300) @(posedge clk);
        #1;
        check("arm_abort_nowr", 32'(wr_cnt0 + wr_cnt1), 32'd0);
        check("arm_abort_noready", 32'(ready_cnt), 32'd0);

        // Abort in the middle of the capture window.
        start = 1'b1;
        wait_writes("cap_abort_started", 10, 4000);
        start = 1'b0;
        ready_cnt = 0;
        @(posedge clk);
        #1;
        check_idle("cap_abort");
        snap0 = wr_cnt0;
        snap1 = wr_cnt1;
        repeat (1000) @(posedge clk);
        #1;
        check("cap_abort_nowr", 32'(wr_cnt0 + wr_cnt1), 32'(snap0 + snap1));
        check("cap_abort_noready", 32'(ready_cnt), 32'd0);

        // Synchronous reset in the middle of the capture window.
        wr_cnt0 = 0;
        start = 1'b1;
        wait_writes("rst_cap_started", 10, 4000);
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("rst_mid_cap");
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check_idle("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
